dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Sits directly downstream of the core's data-memory port (the EX/MEM-stage dmem_* signals).
//  Registers each load/store the core issues and converts it into a word-addressed, byte-lane bus request.
//  Holds a req/ack handshake with the slave and drives dmem_wait so the pipeline freezes until the slave acks.
//  Returns load data shifted down to bit 0; the core does the sign/zero extension in WB.
// PARAMETERS
//  ACK_TIMEOUT  255  cycles in BUSY without bus_ack before the access is aborted; 0 = never abort
//  ERR_DATA     32'h0  value returned on dmem_read_data for an aborted or misaligned load
// PORTS
//  clk                input   1   clock; all state changes on rising edge
//  reset              input   1   asynchronous, active-high reset
//  dmem_address       input   32  byte address from core (EX ALU result)
//  dmem_enable        input   1   core pipe enable; request is sampled only when high
//  dmem_write_data    input   32  store data, right-aligned
//  dmem_write_enable  input   1   store request
//  dmem_write_mode    input   3   000 byte, 001 half, 010 word
//  dmem_read_enable   input   1   load request
//  dmem_read_mode     input   3   000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (bit2 ignored here)
//  dmem_read_data     output  32  load data, shifted so the addressed byte is at [7:0]
//  dmem_wait          output  1   stall request to the core hazard unit
//  bus_req            output  1   request valid; held until ack or abort
//  bus_we             output  1   1 = write
//  bus_addr           output  32  word-aligned address ({addr[31:2],2'b00})
//  bus_be             output  4   byte enables
//  bus_wdata          output  32  lane-replicated store data
//  bus_ack            input   1   slave done; may be high in the same cycle bus_req first rises
//  bus_rdata          input   32  read word; valid only while bus_ack is high
//  timeout            output  1   one-cycle pulse when an access is aborted
// BEHAVIOUR
//  - Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, dmem_wait=0, timeout=0, rdata_q=0 (so dmem_read_data=0).
//  - FSM: IDLE, BUSY.
//    IDLE->BUSY on a clk edge with dmem_enable && (read_enable || write_enable).
//    That edge registers bus_we/addr/be/wdata, the read byte offset and the size; the counter is cleared.
//    If read_enable and write_enable are both high, the write wins and bus_we=1.
//  - BUSY: bus_req=1.
//    dmem_wait = BUSY && !bus_ack && !abort (combinational), so a zero-wait slave costs no stall cycle.
//  - BUSY->IDLE on bus_ack. A read captures rdata_q <= bus_rdata >> (8*offset), zero-filled from the top.
//  - dmem_read_data = (BUSY && bus_ack && !bus_we) ? shifted bus_rdata : rdata_q.
//    It is held until the next load completes, so a load stalled in MEM for another reason (e.g. divider) keeps its data.
//  - Store lanes:
//    byte: be = 4'b0001 << off, wdata = {4{wd[7:0]}}
//    half: be = 4'b0011 << off, wdata = {2{wd[15:0]}}
//    word: be = 4'b1111, wdata = wd
//  - Load lanes: be = 4'b1111 regardless of size.
//  - Counter: increments each BUSY cycle without ack; saturates at ACK_TIMEOUT.
//  - Abort: abort = (ACK_TIMEOUT != 0) && (counter == ACK_TIMEOUT-1) && !bus_ack.
//    On abort: BUSY->IDLE, timeout pulses for 1 cycle, a load sets rdata_q = ERR_DATA, the store is dropped.
//    The abort cycle itself drops dmem_wait.
//  - A request sampled while BUSY is impossible (the core is stalled); it is ignored and flagged by an SVA.
//  - Reset asserted mid-access: bus_req drops asynchronously and the access is discarded, with no ack expected.
//    The slave must tolerate an abandoned request.
// CONFIGURATION
//  DMEM_BRIDGE_MISALIGN_EN
//   Defined:
//    - Half at odd offset, or word at offset != 0, is detected at sample time: no bus access, stay IDLE.
//    - Output port `misaligned` (1 bit, reset 0) pulses for one cycle.
//    - A load sets rdata_q = ERR_DATA; a store is dropped.
//   Undefined:
//    - The port is absent; addr low bits are masked to the access size (half->even, word->aligned) and the access proceeds.
// STRUCTURE
//  - TYPES package additions: typedef enum logic {BR_IDLE, BR_BUSY} bridge_state_t.
//  - TYPES package additions: localparams MEM_BYTE=3'b000, MEM_HALF=3'b001, MEM_WORD=3'b010, MEM_UNSIGNED_BIT=2.
//  - One combinational sub-module dmem_lane_steer(size, offset, wdata -> be, wdata_rep, misaligned).
//  - The FSM, counter and rdata_q stay in dmem_bridge.
// TESTING
//  - Reset: assert reset mid-BUSY -> bus_req=0 same cycle; after release dmem_wait=0, dmem_read_data=0, no bus activity.
//  - sw 0x11223344 @0x100, ack tied high -> bus_addr=0x100, be=1111, wdata=0x11223344, dmem_wait never high.
//  - sb 0xAB @0x203, ack after 3 cycles -> be=1000, wdata=0xABABABAB, dmem_wait high exactly 3 cycles.
//  - lh @0x102, bus_rdata=0xBEEF1234 -> dmem_read_data=0x0000BEEF; held unchanged through 5 idle cycles.
//  - ACK_TIMEOUT=4, lw @0x40, no ack -> wait high 3 cycles, timeout pulse on 4th, bus_req drops, dmem_read_data=ERR_DATA.
//  - lw @0x101: with DMEM_BRIDGE_MISALIGN_EN -> misaligned=1 one cycle, no bus_req, wait 0.
//  - lw @0x101: without DMEM_BRIDGE_MISALIGN_EN -> bus_addr=0x100, be=1111, data unshifted.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
`default_nettype none
// dmem_bridge_pkg: bridge FSM state type, access-size encodings and byte-offset helpers.
package dmem_bridge_pkg;

  typedef enum logic {BR_IDLE = 1'b0, BR_BUSY = 1'b1} bridge_state_t;

  localparam logic [2:0] MEM_BYTE         = 3'b000;
  localparam logic [2:0] MEM_HALF         = 3'b001;
  localparam logic [2:0] MEM_WORD         = 3'b010;
  localparam int         MEM_UNSIGNED_BIT = 2;

  // Half must sit on an even byte, word on offset 0; sizes 011/1xx behave as word.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_BYTE: mis = 1'b0;
      MEM_HALF: mis = off[0];
      default:  mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [1:0] align_offset(input logic [2:0] size, input logic [1:0] off);
    logic [1:0] res;
    res = 2'b00;
    case (size)
      MEM_BYTE: res = off;
      MEM_HALF: res = {off[1], 1'b0};
      MEM_WORD: res = 2'b00;
      default:  res = 2'b00;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_steer.sv
`default_nettype none
// dmem_lane_steer: byte enables and lane-replicated store data for one access size/offset.
module dmem_lane_steer
  import dmem_bridge_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic        misaligned_o
);

  logic [1:0] off_aligned;

  always_comb begin
    off_aligned  = align_offset(size_i, offset_i);
    misaligned_o = is_misaligned(size_i, offset_i);
    be_o         = 4'b1111;
    wdata_rep_o  = wdata_i;
    case (size_i)
      MEM_BYTE: begin
        be_o        = 4'b0001 << off_aligned;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      MEM_HALF: begin
        be_o        = 4'b0011 << off_aligned;
        wdata_rep_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// dmem_bridge: registers core loads/stores into a req/ack word bus and stalls the pipe until ack.
// Optional DMEM_BRIDGE_MISALIGN_EN rejects misaligned accesses instead of masking the address.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_address,
  input  logic        dmem_enable,
  input  logic [31:0] dmem_write_data,
  input  logic        dmem_write_enable,
  input  logic [2:0]  dmem_write_mode,
  input  logic        dmem_read_enable,
  input  logic [2:0]  dmem_read_mode,
  output logic [31:0] dmem_read_data,
  output logic        dmem_wait,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
`ifdef DMEM_BRIDGE_MISALIGN_EN
  output logic        misaligned,
`endif
  output logic        timeout
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  bridge_state_t    state_q, state_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
`ifdef DMEM_BRIDGE_MISALIGN_EN
  logic             mis_q, mis_d;
`endif

  logic        w_req;
  logic        w_is_wr;
  logic [2:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic        w_mis;
  logic        w_abort;
  logic [31:0] w_rd_shift;

  // A store wins over a simultaneous load; the signedness bit of the load mode is the core's business.
  assign w_req   = dmem_enable && (dmem_read_enable || dmem_write_enable);
  assign w_is_wr = dmem_write_enable;
  assign w_size  = w_is_wr ? dmem_write_mode
                           : (dmem_read_mode & ~(3'b001 << MEM_UNSIGNED_BIT));

  dmem_lane_steer u_lane_steer (
    .size_i       (w_size),
    .offset_i     (dmem_address[1:0]),
    .wdata_i      (dmem_write_data),
    .be_o         (w_be),
    .wdata_rep_o  (w_wdata_rep),
    .misaligned_o (w_mis)
  );

`ifdef DMEM_BRIDGE_MISALIGN_EN
  assign w_off = dmem_address[1:0];
`else
  assign w_off = w_mis ? align_offset(w_size, dmem_address[1:0]) : dmem_address[1:0];
`endif

  assign w_abort    = (ACK_TIMEOUT != 0) && (state_q == BR_BUSY) && (cnt_q == CNT_LAST) && !bus_ack;
  assign w_rd_shift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef DMEM_BRIDGE_MISALIGN_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      BR_IDLE: begin
        if (w_req) begin
`ifdef DMEM_BRIDGE_MISALIGN_EN
          if (w_mis) begin
            mis_d = 1'b1;
            if (!w_is_wr) rdata_d = ERR_DATA;
          end else
`endif
          begin
            state_d = BR_BUSY;
            we_d    = w_is_wr;
            addr_d  = {dmem_address[31:2], 2'b00};
            be_d    = w_is_wr ? w_be : 4'b1111;
            wdata_d = w_wdata_rep;
            off_d   = w_off;
            cnt_d   = '0;
          end
        end
      end
      BR_BUSY: begin
        if (bus_ack) begin
          state_d = BR_IDLE;
          if (!we_q) rdata_d = w_rd_shift;
        end else if (w_abort) begin
          state_d = BR_IDLE;
          if (!we_q) rdata_d = ERR_DATA;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BR_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef DMEM_BRIDGE_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef DMEM_BRIDGE_MISALIGN_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign bus_req        = (state_q == BR_BUSY);
  assign bus_we         = we_q;
  assign bus_addr       = addr_q;
  assign bus_be         = be_q;
  assign bus_wdata      = wdata_q;
  assign dmem_wait      = (state_q == BR_BUSY) && !bus_ack && !w_abort;
  assign timeout        = w_abort;
  assign dmem_read_data = ((state_q == BR_BUSY) && bus_ack && !we_q) ? w_rd_shift : rdata_q;
`ifdef DMEM_BRIDGE_MISALIGN_EN
  assign misaligned     = mis_q;
`endif

  // The core is frozen while dmem_wait is high, so it cannot present a new access then.
  a_no_req_while_stalled: assert property (@(posedge clk) disable iff (reset) dmem_wait |-> !w_req);

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// tb_dmem_bridge: randomized and directed checks of dmem_bridge against a behavioural model.
module tb_dmem_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dmem_address = '0;
  logic        dmem_enable = 1'b0;
  logic [31:0] dmem_write_data = '0;
  logic        dmem_write_enable = 1'b0;
  logic [2:0]  dmem_write_mode = '0;
  logic        dmem_read_enable = 1'b0;
  logic [2:0]  dmem_read_mode = '0;
  logic [31:0] dmem_read_data;
  logic        dmem_wait;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        timeout;
`ifdef DMEM_BRIDGE_MISALIGN_EN
  logic        misaligned;
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  dmem_bridge #(.ACK_TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk               (clk),
    .reset             (reset),
    .dmem_address      (dmem_address),
    .dmem_enable       (dmem_enable),
    .dmem_write_data   (dmem_write_data),
    .dmem_write_enable (dmem_write_enable),
    .dmem_write_mode   (dmem_write_mode),
    .dmem_read_enable  (dmem_read_enable),
    .dmem_read_mode    (dmem_read_mode),
    .dmem_read_data    (dmem_read_data),
    .dmem_wait         (dmem_wait),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_be            (bus_be),
    .bus_wdata         (bus_wdata),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata),
`ifdef DMEM_BRIDGE_MISALIGN_EN
    .misaligned        (misaligned),
`endif
    .timeout           (timeout)
  );

  // Reference model: access size in bytes and the byte offset the access really uses.
  function automatic int nbytes(input logic we, input logic [2:0] wm, input logic [2:0] rm);
    int m;
    m = we ? int'(wm) : int'(rm) % 4;
    return (m == 0) ? 1 : (m == 1) ? 2 : 4;
  endfunction

  function automatic int eff_off(input int nb, input logic [31:0] a);
    return int'(a % 4) - int'(a % 4) % nb;
  endfunction

  function automatic logic [31:0] rep_data(input int nb, input logic [31:0] wd);
    if (nb == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
    if (nb == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  // One access from the core plus a slave that acks `delay` cycles after bus_req rises.
  task automatic drive_access(
    input  logic we, input logic re, input logic [2:0] wm, input logic [2:0] rm,
    input  logic [31:0] a, input logic [31:0] wd, input int delay, input logic [31:0] word,
    output logic req0, output logic we0, output logic [31:0] addr0, output logic [3:0] be0,
    output logic [31:0] wdata0, output logic mis0, output int waits, output int to_cnt,
    output int to_cyc, output logic [31:0] rd_done, output logic req_after,
    output logic [31:0] rd_after, output logic done);
    dmem_enable = 1'b1; dmem_write_enable = we; dmem_read_enable = re;
    dmem_write_mode = wm; dmem_read_mode = rm; dmem_address = a; dmem_write_data = wd;
    @(posedge clk); #1;
    dmem_enable = 1'b0; dmem_write_enable = 1'b0; dmem_read_enable = 1'b0;
    waits = 0; to_cnt = 0; to_cyc = -1; done = 1'b0; rd_done = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0; mis0 = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      bus_ack   = bus_req && (c == delay);
      bus_rdata = bus_ack ? word : $urandom;
      #1;
      if (c == 0) begin
        req0 = bus_req; we0 = bus_we; addr0 = bus_addr; be0 = bus_be; wdata0 = bus_wdata;
`ifdef DMEM_BRIDGE_MISALIGN_EN
        mis0 = misaligned;
`endif
      end
      if (dmem_wait) waits++;
      if (timeout) begin
        to_cnt++;
        if (to_cyc < 0) to_cyc = c;
      end
      if (!bus_req) done = 1'b1;
      else if (bus_ack || timeout) begin
        done = 1'b1;
        rd_done = dmem_read_data;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    #1;
    req_after = bus_req;
    rd_after  = dmem_read_data;
  endtask

  logic r0, w0, m0, ra, dn;
  logic [31:0] ad0, wd0, rdd, rda;
  logic [3:0] b0;
  int nw, ntc, tcy;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus_req, bus_we, dmem_wait, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {bus_req, bus_we, dmem_wait, timeout});
    end
    checks++;
    if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_bus got %h/%h/%h want 0", bus_addr, bus_be, bus_wdata);
    end
    checks++;
    if (dmem_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", dmem_read_data);
    end
    drive_access(1'b0, 1'b1, 3'b000, 3'b010, 32'h0, 32'h0, 0, 32'h5A5A_1234,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    checks++;
    if (rda !== 32'h5A5A_1234) begin
      errors++; $display("FAIL seed_load got %h want %h", rda, 32'h5A5A_1234);
    end
    dmem_enable = 1'b1; dmem_read_enable = 1'b1; dmem_read_mode = 3'b010; dmem_address = 32'h8;
    @(posedge clk); #1;
    dmem_enable = 1'b0; dmem_read_enable = 1'b0;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL busy_before_reset got %b want 1", bus_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, dmem_wait} !== 2'b00) begin
      errors++; $display("FAIL reset_async_drop got %b want 00", {bus_req, dmem_wait});
    end
    @(posedge clk); #3 reset = 1'b0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus_req, dmem_wait, dmem_read_data} !== 34'h0) begin
        errors++; $display("FAIL post_reset_idle cyc %0d got %b%b/%h want 00/0", i, bus_req, dmem_wait, dmem_read_data);
      end
    end
  endtask

  task automatic test_store_word();
    drive_access(1'b1, 1'b0, 3'b010, 3'b000, 32'h100, 32'h1122_3344, 0, 32'h0,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    checks++;
    if ({r0, w0, ad0, b0, wd0} !== {1'b1, 1'b1, 32'h100, 4'b1111, 32'h1122_3344}) begin
      errors++; $display("FAIL sw_bus got req%b we%b %h %b %h want 1 1 00000100 1111 11223344", r0, w0, ad0, b0, wd0);
    end
    checks++;
    if ({nw, ra, dn} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sw_wait got waits %0d req_after %b done %b want 0 0 1", nw, ra, dn);
    end
  endtask

  task automatic test_store_byte();
    drive_access(1'b1, 1'b0, 3'b000, 3'b000, 32'h203, 32'h0000_00AB, 3, 32'h0,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    checks++;
    if ({ad0, b0, wd0} !== {32'h200, 4'b1000, 32'hABAB_ABAB}) begin
      errors++; $display("FAIL sb_lanes got %h %b %h want 00000200 1000 abababab", ad0, b0, wd0);
    end
    checks++;
    if ({nw, ntc, dn} !== {32'd3, 32'd0, 1'b1}) begin
      errors++; $display("FAIL sb_wait got waits %0d timeouts %0d done %b want 3 0 1", nw, ntc, dn);
    end
  endtask

  task automatic test_load_half();
    drive_access(1'b0, 1'b1, 3'b000, 3'b001, 32'h102, 32'h0, 1, 32'hBEEF_1234,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    held = 32'h0000_BEEF;
    checks++;
    if ({w0, ad0, b0, rdd} !== {1'b0, 32'h100, 4'b1111, 32'h0000_BEEF}) begin
      errors++; $display("FAIL lh_data got we%b %h %b %h want 0 00000100 1111 0000beef", w0, ad0, b0, rdd);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dmem_read_data !== 32'h0000_BEEF) begin
        errors++; $display("FAIL lh_hold cyc %0d got %h want 0000beef", i, dmem_read_data);
      end
    end
  endtask

  task automatic test_timeout();
    drive_access(1'b0, 1'b1, 3'b000, 3'b010, 32'h40, 32'h0, 99, 32'h0,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    held = ERR;
    checks++;
    if ({nw, ntc, tcy} !== {32'd3, 32'd1, 32'd3}) begin
      errors++; $display("FAIL timeout_pulse got waits %0d pulses %0d at %0d want 3 1 3", nw, ntc, tcy);
    end
    checks++;
    if ({ra, rda} !== {1'b0, ERR}) begin
      errors++; $display("FAIL timeout_after got req%b %h want 0 %h", ra, rda, ERR);
    end
  endtask

  task automatic test_misaligned();
    drive_access(1'b0, 1'b1, 3'b000, 3'b010, 32'h101, 32'h0, 0, 32'hCAFE_F00D,
                 r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
    if (MIS_EN) begin
      held = ERR;
      checks++;
      if ({r0, m0, nw} !== {1'b0, 1'b1, 32'd0}) begin
        errors++; $display("FAIL lw_mis_flag got req%b mis%b waits %0d want 0 1 0", r0, m0, nw);
      end
    end else begin
      held = 32'hCAFE_F00D;
      checks++;
      if ({r0, ad0, b0, rdd} !== {1'b1, 32'h100, 4'b1111, 32'hCAFE_F00D}) begin
        errors++; $display("FAIL lw_mask got req%b %h %b %h want 1 00000100 1111 cafef00d", r0, ad0, b0, rdd);
      end
    end
    checks++;
    if ({ra, rda} !== {1'b0, held}) begin
      errors++; $display("FAIL lw_mis_after got req%b %h want 0 %h", ra, rda, held);
    end
  endtask

  task automatic test_random();
    logic [2:0] rmodes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 40; n++) begin
      logic we, re, mis, fin;
      logic [2:0] wm, rm;
      logic [31:0] a, wd, word, exp_rd;
      logic [3:0] exp_be;
      int nb, off, dly;
      we   = 1'($urandom);
      re   = we ? 1'($urandom) : 1'b1;
      wm   = 3'($urandom_range(0, 2));
      rm   = rmodes[$urandom_range(0, 4)];
      a    = $urandom;
      wd   = $urandom;
      word = $urandom;
      dly  = $urandom_range(0, 6);
      nb   = nbytes(we, wm, rm);
      off  = eff_off(nb, a);
      mis  = (a % nb) != 0;
      fin  = dly < TO;
      exp_be = we ? 4'(((1 << nb) - 1) << off) : 4'b1111;
      exp_rd = word >> (8 * off);
      drive_access(we, re, wm, rm, a, wd, dly, word,
                   r0, w0, ad0, b0, wd0, m0, nw, ntc, tcy, rdd, ra, rda, dn);
      if (MIS_EN && mis) begin
        if (!we) held = ERR;
        checks++;
        if ({r0, m0, nw} !== {1'b0, 1'b1, 32'd0}) begin
          errors++; $display("FAIL rnd%0d_reject got req%b mis%b waits %0d want 0 1 0", n, r0, m0, nw);
        end
      end else begin
        checks++;
        if ({r0, w0, ad0, b0, m0} !== {1'b1, we, a & 32'hFFFF_FFFC, exp_be, 1'b0}) begin
          errors++; $display("FAIL rnd%0d_req got %b %b %h %b mis%b want 1 %b %h %b 0", n, r0, w0, ad0, b0, m0, we, a & 32'hFFFF_FFFC, exp_be);
        end
        if (we) begin
          checks++;
          if (wd0 !== rep_data(nb, wd)) begin
            errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, wd0, rep_data(nb, wd));
          end
        end
        checks++;
        if ({nw, ntc} !== {fin ? dly : TO - 1, fin ? 0 : 1}) begin
          errors++; $display("FAIL rnd%0d_handshake got waits %0d timeouts %0d want %0d %0d", n, nw, ntc, fin ? dly : TO - 1, fin ? 0 : 1);
        end
        if (!we && fin) begin
          held = exp_rd;
          checks++;
          if (rdd !== exp_rd) begin
            errors++; $display("FAIL rnd%0d_load got %h want %h", n, rdd, exp_rd);
          end
        end else if (!we) begin
          held = ERR;
        end
      end
      checks++;
      if ({ra, rda} !== {1'b0, held}) begin
        errors++; $display("FAIL rnd%0d_after got req%b %h want 0 %h", n, ra, rda, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_half();
    test_timeout();
    test_misaligned();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
